// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding, the
// default operand width and the iteration-counter width helper.
// Imported by seq_divider and sub_stage.
package div_pkg;

  // Default operand / quotient / remainder width.
  localparam int DIV_WIDTH = 32;

  // Counter must hold values 0..WIDTH-1 with headroom for the increment.
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Counter width for an arbitrary operand width.
  function automatic int div_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build ripple arithmetic.
// Ports: a_i, b_i, ci_i -> s_o (sum), co_o (carry out).
// Purely combinational.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  logic axb;

  assign axb  = a_i ^ b_i;
  assign s_o  = axb ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & axb);

endmodule

// File: rtl/sub_stage.sv
// Combinational W-bit subtractor diff = a - b built from a ripple of full
// adders: a + ~b + 1. Ports: a_i, b_i (minuend, subtrahend), diff_o,
// borrow_o (1 when b_i > a_i, i.e. the final carry-out is 0).
module sub_stage
  import div_pkg::*;
#(
  parameter int W = DIV_WIDTH + 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  logic [W:0]   carry;
  logic [W-1:0] b_inv;

  // Two's-complement subtract: invert subtrahend, inject carry-in of 1.
  assign b_inv    = ~b_i;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (
      .a_i  (a_i[i]),
      .b_i  (b_inv[i]),
      .ci_i (carry[i]),
      .s_o  (diff_o[i]),
      .co_o (carry[i+1])
    );
  end

  // No carry-out means the subtraction wrapped: a borrow occurred.
  assign borrow_o = ~carry[W];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst (sync, active-high), start/ready handshake with dividend
// and divisor; done pulse with registered quotient, remainder, div_by_zero.
// Latency: WIDTH+1 edges from accept to done (1 edge for a zero divisor).
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int               CNT_W    = div_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;

  // Partial remainder. It always stays below the divisor, so its MSB only
  // matters inside the trial subtract on the shifted value.
  logic [WIDTH:0]   prem_q, prem_d;

  // Dividend shift register: unconsumed dividend bits leave at the MSB
  // while quotient bits enter at the LSB, so after WIDTH steps it holds
  // the complete quotient.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;

  logic             ready_q, done_q, dbz_q;
  logic [WIDTH-1:0] quo_q, rem_q;

  logic             unused_prem_msb;
  assign unused_prem_msb = prem_q[WIDTH];

  // Trial-subtract datapath.
  assign shifted = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};

  sub_stage #(
    .W (WIDTH + 1)
  ) u_sub (
    .a_i      (shifted),
    .b_i      ({1'b0, dvs_q}),
    .diff_o   (trial),
    .borrow_o (borrow)
  );

  always_comb begin
    prem_d = shifted;
    dvd_d  = {dvd_q[WIDTH-2:0], ~borrow};
    // Restore (keep the shifted value) when the subtract borrowed.
    if (!borrow) begin
      prem_d = trial;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q   <= dividend;
            dvs_q   <= divisor;
            ready_q <= 1'b0;
            if (divisor == '0) begin
              // Zero divisor bypasses the iteration entirely.
              quo_q   <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              prem_q  <= '0;
              cnt_q   <= '0;
              dbz_q   <= 1'b0;
              state_q <= RUN;
            end
          end
        end

        RUN: begin
          prem_q <= prem_d;
          dvd_q  <= dvd_d;
          cnt_q  <= cnt_q + CNT_ONE;
          if (cnt_q == LAST_CNT) begin
            // Last quotient bit is produced this edge: publish results.
            quo_q   <= dvd_d;
            rem_q   <= prem_d[WIDTH-1:0];
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus randomized
// divides, scoreboard filled on every accepted request and drained by a
// monitor whenever done pulses.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           done_cyc;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name,
                       input logic [71:0] act, input logic [71:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain integer division, zero divisor yields all-ones
  // quotient and the dividend as remainder.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int done_cyc);
    exp_t e;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
      e.dbz = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dbz = 1'b0;
    end
    e.done_cyc = done_cyc;
    return e;
  endfunction

  // Monitor / scoreboard, sampled mid-cycle.
  logic [W-1:0] hold_q = '0, hold_r = '0;
  logic         hold_dbz = 1'b0;
  bit           prev_rst = 1'b0, prev_done = 1'b0;
  int           last_acc = 0, last_gap = 0;

  always @(negedge clk) begin
    if (prev_rst) begin
      check({ready, done, div_by_zero, quotient, remainder} == {1'b1, 1'b0, 1'b0, 64'h0},
            "reset_state", {5'b0, ready, done, div_by_zero, quotient, remainder},
            {5'b0, 1'b1, 1'b0, 1'b0, 64'h0});
    end else if (done) begin
      if (sb.size() == 0) begin
        check(1'b0, "unexpected_done", {40'b0, quotient}, 72'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(quotient == e.q, "quotient", {40'b0, quotient}, {40'b0, e.q});
        check(remainder == e.r, "remainder", {40'b0, remainder}, {40'b0, e.r});
        check(div_by_zero == e.dbz, "div_by_zero", {71'b0, div_by_zero}, {71'b0, e.dbz});
        check(cyc == e.done_cyc, "done_latency", 72'(cyc), 72'(e.done_cyc));
        check(ready == 1'b0, "ready_low_in_done", {71'b0, ready}, 72'h0);
        hold_q   = e.q;
        hold_r   = e.r;
        hold_dbz = e.dbz;
      end
    end else begin
      check({quotient, remainder, div_by_zero} == {hold_q, hold_r, hold_dbz}, "output_hold",
            {7'b0, quotient, remainder, div_by_zero}, {7'b0, hold_q, hold_r, hold_dbz});
    end

    if (!rst && ready && start) begin
      // Accept happens at the coming edge, numbered cyc+1.
      if (prev_done) begin
        check((cyc + 1 - last_acc) == last_gap, "back_to_back_period",
              72'(cyc + 1 - last_acc), 72'(last_gap));
      end
      sb.push_back(model(dividend, divisor, cyc + 1 + ((divisor == 0) ? 0 : W)));
      last_acc = cyc + 1;
      last_gap = (divisor == 0) ? 2 : W + 2;
      if (divisor != 0) hold_dbz = 1'b0;
    end

    if (rst) begin
      sb.delete();
      hold_q   = '0;
      hold_r   = '0;
      hold_dbz = 1'b0;
    end
    prev_rst  = rst;
    prev_done = done;
  end

  // Drivers operate 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and wait until it is accepted; optionally leave start
  // asserted so the next request follows back-to-back.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
    int guard = 0;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    while (!ready && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) check(1'b0, "ready_timeout", 72'(guard), 72'd200);
    tick();
    if (!keep) start = 1'b0;
  endtask

  initial begin
    int g;
    logic [W-1:0] a, b;
    bit keep;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Directed cases.
    issue(32'd100, 32'd7, 1'b0);
    issue(32'd5, 32'd0, 1'b0);
    issue(32'd9, 32'd3, 1'b0);
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    issue(32'd3, 32'd10, 1'b0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Starts during RUN must be ignored.
    issue(32'd1234567, 32'd89, 1'b0);   // now in RUN cycle 1
    repeat (4) tick();
    dividend = 32'd77; divisor = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    dividend = 32'hDEAD_BEEF; divisor = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;

    // Reset mid-operation aborts; then a fresh divide.
    issue(32'd555555, 32'd17, 1'b0);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    issue(32'd1000, 32'd33, 1'b0);

    // Reset and start on the same edge: start dropped.
    g = 0;
    while (!ready && g < 200) begin tick(); g++; end
    rst = 1'b1; start = 1'b1; dividend = 32'd50; divisor = 32'd6;
    tick();
    rst = 1'b0; start = 1'b0;
    tick();

    // Randomized divides, mixing held-start back-to-back and gapped requests.
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = '1;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = $urandom >> $urandom_range(0, 31);
      else                           a = $urandom;
      keep = ($urandom_range(0, 1) == 1) && (i != 1999);
      issue(a, b, keep);
      if (!keep && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick();
    end
    start = 1'b0;

    g = 0;
    while (sb.size() != 0 && g < 200) begin tick(); g++; end
    check(sb.size() == 0, "drain", 72'(sb.size()), 72'h0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
